// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus scheduler: FSM encoding, poll address map,
// snapshot layout and the per-state bus drive decode.
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_HOLD,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_HOLD
    } bus_state_e;

    localparam int N_POLL = 9;
    localparam int SNAP_W = 8 * N_POLL;

    // seg, min, hora, dia, mes, anno, tseg, tmin, thora
    localparam logic [7:0] POLL_ADDR [N_POLL] = '{
        8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43
    };

    // Field 0 (seg) occupies the top byte of the snapshot.
    function automatic int snap_lsb(input int field);
        return SNAP_W - 8 * (field + 1);
    endfunction

    typedef struct packed {
        logic       ad;
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       oe;
        logic [7:0] dout;
    } bus_out_t;

    localparam bus_out_t BUS_IDLE = '{ad: 1'b1, cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                      oe: 1'b0, dout: 8'h00};

    function automatic bus_out_t bus_drive(input bus_state_e st, input logic is_write,
                                           input logic [7:0] addr, input logic [7:0] data);
        bus_out_t b;
        b = BUS_IDLE;
        case (st)
            ST_A_SETUP, ST_A_HOLD: begin
                b.ad   = 1'b0;
                b.oe   = 1'b1;
                b.dout = addr;
            end
            ST_A_STROBE: begin
                b.ad   = 1'b0;
                b.oe   = 1'b1;
                b.dout = addr;
                b.cs_n = 1'b0;
                b.wr_n = 1'b0;
            end
            ST_D_SETUP, ST_D_HOLD: begin
                b.oe   = is_write;
                b.dout = is_write ? data : 8'h00;
            end
            ST_D_STROBE: begin
                b.oe   = is_write;
                b.dout = is_write ? data : 8'h00;
                b.cs_n = 1'b0;
                b.rd_n = is_write;
                b.wr_n = ~is_write;
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Bus phase timer: counts 0..T_PHASE-1 and flags the final cycle of a phase.
module rtc_phase_timer #(
    parameter int T_PHASE = 10,
    parameter int CW      = $clog2(T_PHASE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          last_cycle
);

    localparam logic [CW-1:0] LAST = CW'(T_PHASE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_cycle = (cnt_q == LAST);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Sequencer/arbiter for the multiplexed RTC bus: periodic 9-register poll sweep into a
// coherent snapshot, with user writes interleaved between poll reads.
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | arbitrate: pending write, else next poll read
// A_SETUP   | address on bus, ad=0, strobes high
// A_STROBE  | cs_n/wr_n low to latch the address
// A_HOLD    | address held, strobes high
// D_SETUP   | ad=1; write data driven, or bus released for a read
// D_STROBE  | cs_n plus rd_n or wr_n low; read data captured on last cycle
// D_HOLD    | strobes high, oe as in D_SETUP
module rtc_bus_scheduler #(
    parameter int T_PHASE     = 10,
    parameter int REFRESH_DIV = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_req,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        busy,
    output logic        sweep_done,
    output logic [71:0] snap,
    output logic        rtc_ad,
    output logic        rtc_cs_n,
    output logic        rtc_rd_n,
    output logic        rtc_wr_n,
    output logic        rtc_oe,
    output logic [7:0]  rtc_dout,
    input  logic [7:0]  rtc_din
);

    import rtc_pkg::*;

    localparam int              RW       = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0]   REF_LAST = RW'(REFRESH_DIV - 1);

    bus_state_e        state_q, state_d;
    logic              is_write_q, is_write_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [3:0]        idx_q, idx_d;
    logic              sweep_q, sweep_d;
    logic [RW-1:0]     refresh_q, refresh_d;
    logic [7:0]        shadow_q [N_POLL];
    logic [7:0]        shadow_d [N_POLL];
    logic [SNAP_W-1:0] snap_q, snap_d;
    logic              wr_ack_q, wr_ack_d;
    logic              done_q, done_d;
    bus_out_t          bus_q, bus_d;

    logic tick;
    logic phase_last;
    logic phase_clear;

    assign tick        = (refresh_q == REF_LAST);
    assign phase_clear = (state_d != state_q) || (state_q == ST_IDLE);

    rtc_phase_timer #(.T_PHASE(T_PHASE)) u_phase_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (phase_clear),
        .load       (1'b0),
        .load_val   ('0),
        .last_cycle (phase_last)
    );

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        sweep_d    = sweep_q;
        shadow_d   = shadow_q;
        snap_d     = snap_q;
        wr_ack_d   = 1'b0;
        done_d     = 1'b0;
        refresh_d  = tick ? '0 : refresh_q + 1'b1;

        // A tick during an active sweep is dropped rather than queued.
        if (tick && !sweep_q) begin
            sweep_d = 1'b1;
            idx_d   = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    state_d    = ST_A_SETUP;
                    is_write_d = 1'b1;
                    addr_d     = wr_addr;
                    data_d     = wr_data;
                end else if (sweep_q) begin
                    state_d    = ST_A_SETUP;
                    is_write_d = 1'b0;
                    addr_d     = POLL_ADDR[idx_q];
                    data_d     = 8'h00;
                end
            end
            ST_A_SETUP:  if (phase_last) state_d = ST_A_STROBE;
            ST_A_STROBE: if (phase_last) state_d = ST_A_HOLD;
            ST_A_HOLD:   if (phase_last) state_d = ST_D_SETUP;
            ST_D_SETUP:  if (phase_last) state_d = ST_D_STROBE;
            ST_D_STROBE: begin
                if (phase_last) begin
                    state_d = ST_D_HOLD;
                    if (!is_write_q) shadow_d[idx_q] = rtc_din;
                end
            end
            ST_D_HOLD: begin
                if (phase_last) begin
                    state_d = ST_IDLE;
                    if (is_write_q) begin
                        wr_ack_d = 1'b1;
                    end else if (idx_q == 4'd8) begin
                        // Whole snapshot commits in one cycle so the VGA side never sees a mix.
                        for (int i = 0; i < N_POLL; i++) begin
                            snap_d[snap_lsb(i) +: 8] = shadow_q[i];
                        end
                        done_d  = 1'b1;
                        sweep_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bus_d = bus_drive(state_d, is_write_d, addr_d, data_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            idx_q      <= '0;
            sweep_q    <= 1'b0;
            refresh_q  <= '0;
            for (int i = 0; i < N_POLL; i++) shadow_q[i] <= 8'h00;
            snap_q     <= '0;
            wr_ack_q   <= 1'b0;
            done_q     <= 1'b0;
            bus_q      <= BUS_IDLE;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            sweep_q    <= sweep_d;
            refresh_q  <= refresh_d;
            shadow_q   <= shadow_d;
            snap_q     <= snap_d;
            wr_ack_q   <= wr_ack_d;
            done_q     <= done_d;
            bus_q      <= bus_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign wr_ack     = wr_ack_q;
    assign sweep_done = done_q;
    assign snap       = snap_q;
    assign rtc_ad     = bus_q.ad;
    assign rtc_cs_n   = bus_q.cs_n;
    assign rtc_rd_n   = bus_q.rd_n;
    assign rtc_wr_n   = bus_q.wr_n;
    assign rtc_oe     = bus_q.oe;
    assign rtc_dout   = bus_q.dout;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Scoreboard bench for rtc_bus_scheduler with a behavioural RTC on the bus side.
module tb_rtc_bus_scheduler;

    localparam int T_PHASE     = 4;
    localparam int REFRESH_DIV = 1024;
    localparam logic [71:0] SNAP_EXP =
        {8'hDE, 8'hDD, 8'hDC, 8'hDB, 8'hDA, 8'hD9, 8'hBE, 8'hBD, 8'hBC};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_req = 1'b0;
    logic [7:0]  wr_addr = 8'h00;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_ack, busy, sweep_done;
    logic [71:0] snap;
    logic        rtc_ad, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_oe;
    logic [7:0]  rtc_dout, rtc_din;

    rtc_bus_scheduler #(.T_PHASE(T_PHASE), .REFRESH_DIV(REFRESH_DIV)) dut (
        .clock(clock), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .busy(busy), .sweep_done(sweep_done), .snap(snap),
        .rtc_ad(rtc_ad), .rtc_cs_n(rtc_cs_n), .rtc_rd_n(rtc_rd_n), .rtc_wr_n(rtc_wr_n),
        .rtc_oe(rtc_oe), .rtc_dout(rtc_dout), .rtc_din(rtc_din)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int conflicts = 0;
    int glitches = 0;

    // RTC model: address latched on wr_n rise in address phase, data written on wr_n rise in data phase.
    logic [7:0] lat = 8'h00;
    logic [7:0] mem [256];
    logic       prev_wr_n = 1'b1;
    logic       model_drive;

    assign model_drive = (rtc_rd_n === 1'b0) && (rtc_cs_n === 1'b0);
    assign rtc_din     = model_drive ? ~lat : 8'h00;

    always @(negedge clock) begin
        if (prev_wr_n === 1'b0 && rtc_wr_n === 1'b1) begin
            if (rtc_ad === 1'b0) lat = rtc_dout;
            else mem[lat] = rtc_dout;
        end
        prev_wr_n = rtc_wr_n;
    end

    typedef struct {
        bit          is_snap;
        int          cyc;
        logic [71:0] snap;
    } exp_t;
    exp_t expq[$];

    task automatic push_ack(input int c);
        exp_t e;
        e.is_snap = 1'b0;
        e.cyc     = c;
        e.snap    = '0;
        expq.push_back(e);
    endtask

    task automatic push_snap(input int c, input logic [71:0] v);
        exp_t e;
        e.is_snap = 1'b1;
        e.cyc     = c;
        e.snap    = v;
        expq.push_back(e);
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [71:0] prev_snap = '0;

    always @(negedge clock) begin
        exp_t e;
        if (wr_ack === 1'b1 || sweep_done === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got ack=%b done=%b at cycle %0d, expected none",
                         wr_ack, sweep_done, cyc);
            end else begin
                e = expq.pop_front();
                if (e.is_snap != (sweep_done === 1'b1) || e.cyc != cyc ||
                    (e.is_snap && snap !== e.snap)) begin
                    failures++;
                    $display("FAIL scoreboard: got ack=%b done=%b cycle=%0d snap=%h, expected %s at cycle %0d snap=%h",
                             wr_ack, sweep_done, cyc, snap, e.is_snap ? "sweep_done" : "wr_ack",
                             e.cyc, e.snap);
                end
            end
        end
        if (rtc_oe === 1'b1 && model_drive) conflicts++;
        if (reset !== 1'b1 && snap !== prev_snap && sweep_done !== 1'b1) glitches++;
        prev_snap = snap;
    end

    initial begin
        goto(2);
        chk("reset_outputs",
            {rtc_ad, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_oe, rtc_dout, busy, wr_ack, sweep_done},
            {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        chk("reset_snap", snap, 72'h0);
        goto(3);
        reset = 1'b0;

        // Plain write in IDLE
        goto(9);
        wr_req = 1'b1; wr_addr = 8'h22; wr_data = 8'h45;
        push_ack(34);
        goto(10);
        chk("wr_a_setup", {busy, rtc_ad, rtc_oe, rtc_cs_n, rtc_wr_n, rtc_dout},
            {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22});
        goto(14);
        chk("wr_a_strobe", {rtc_ad, rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_dout},
            {1'b0, 1'b0, 1'b0, 1'b1, 8'h22});
        goto(22);
        chk("wr_d_setup", {rtc_ad, rtc_oe, rtc_cs_n, rtc_dout}, {1'b1, 1'b1, 1'b1, 8'h45});
        goto(26);
        chk("wr_d_strobe", {rtc_ad, rtc_oe, rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_dout},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h45});
        goto(34);
        wr_req = 1'b0;
        goto(35);
        chk("wr_back_idle", {busy, rtc_cs_n, rtc_oe}, {1'b0, 1'b1, 1'b0});
        chk("model_reg22", mem[8'h22], 8'h45);

        // First sweep: tick at edge 1027, reads start 1028, commit at 1027 + 9*25
        goto(500);
        push_snap(1252, SNAP_EXP);
        goto(1027);
        chk("tick_edge_idle", busy, 1'b0);
        goto(1028);
        chk("poll0_a_setup", {busy, rtc_ad, rtc_oe, rtc_dout}, {1'b1, 1'b0, 1'b1, 8'h21});
        goto(1040);
        chk("poll0_d_setup", {rtc_ad, rtc_oe, rtc_cs_n, rtc_rd_n}, {1'b1, 1'b0, 1'b1, 1'b1});
        goto(1044);
        chk("poll0_d_strobe", {rtc_ad, rtc_oe, rtc_cs_n, rtc_rd_n, rtc_wr_n},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        goto(1200);
        chk("snap_before_done", snap, 72'h0);
        goto(1253);
        chk("snap_after_sweep1", snap, SNAP_EXP);

        // Second sweep with a write raised during poll idx 3
        goto(1300);
        push_ack(2176);
        push_snap(2301, SNAP_EXP);
        goto(2127);
        chk("poll3_a_setup", {rtc_ad, rtc_dout}, {1'b0, 8'h24});
        goto(2130);
        wr_req = 1'b1; wr_addr = 8'h30; wr_data = 8'h5A;
        goto(2151);
        chk("poll3_completes", busy, 1'b0);
        goto(2152);
        chk("mid_write_a_setup", {busy, rtc_ad, rtc_oe, rtc_dout}, {1'b1, 1'b0, 1'b1, 8'h30});
        goto(2176);
        wr_req = 1'b0;
        goto(2177);
        chk("poll4_after_write", {rtc_ad, rtc_oe, rtc_dout}, {1'b0, 1'b1, 8'h25});
        goto(2200);
        chk("snap_mid_sweep2", snap, SNAP_EXP);
        goto(2302);
        chk("model_reg30", mem[8'h30], 8'h5A);

        // Third sweep stalled by back-to-back writes across the tick at 4099
        goto(3000);
        for (int n = 0; n < 42; n++) push_ack(3125 + 25 * n);
        push_snap(4350, SNAP_EXP);
        goto(3080);
        wr_req = 1'b1; wr_addr = 8'h31; wr_data = 8'h11;
        goto(3101);
        chk("chained_write0", {rtc_ad, rtc_dout}, {1'b0, 8'h31});
        goto(4099);
        chk("tick_during_sweep_busy", busy, 1'b1);
        goto(4150);
        wr_req = 1'b0;
        goto(4151);
        chk("poll1_resume", {rtc_ad, rtc_dout}, {1'b0, 8'h22});

        // Tick and write in the same IDLE cycle
        goto(5122);
        wr_req = 1'b1; wr_addr = 8'h32; wr_data = 8'h66;
        push_ack(5147);
        push_snap(5372, SNAP_EXP);
        goto(5123);
        chk("tick_write_first", {busy, rtc_ad, rtc_dout}, {1'b1, 1'b0, 8'h32});
        goto(5147);
        wr_req = 1'b0;
        goto(5148);
        chk("sweep_after_write", {rtc_ad, rtc_dout}, {1'b0, 8'h21});

        // Reset during D_STROBE of a write
        goto(5399);
        wr_req = 1'b1; wr_addr = 8'h33; wr_data = 8'h77;
        goto(5417);
        chk("pre_reset_d_strobe", {rtc_ad, rtc_cs_n, rtc_wr_n, rtc_oe, rtc_dout},
            {1'b1, 1'b0, 1'b0, 1'b1, 8'h77});
        reset = 1'b1;
        goto(5418);
        chk("reset_mid_strobe",
            {rtc_ad, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_oe, busy, wr_ack, rtc_dout},
            {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        chk("reset_snap_cleared", snap, 72'h0);
        wr_req = 1'b0;
        goto(5419);
        reset = 1'b0;
        goto(5480);

        chk("queue_drained", 72'(expq.size()), 72'd0);
        chk("oe_contention", 72'(conflicts), 72'd0);
        chk("snap_glitches", 72'(glitches), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
